// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state encoding and word geometry for the FIFO byte-to-word packer.
package fifo_pkg;
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD
    } state_t;
endpackage

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: reads bytes from an upstream FIFO and packs them little-endian
// into 32-bit words, emitting partial words on flush or after an idle timeout.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int TIMEOUT  = 8,
    parameter int MAX_DATA = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(MAX_DATA+1)-1:0] fifo_count,
    output logic                          fifo_ren,
    input  logic [7:0]                    fifo_rdata,
    input  logic                          flush,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [8*BYTES_PER_WORD-1:0]   m_data,
    output logic [BYTES_PER_WORD-1:0]     m_keep
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
    localparam int CW = $clog2(BYTES_PER_WORD + 1);
    localparam int LW = $clog2(BYTES_PER_WORD);
    localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD - 1);

    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [LW-1:0] lane;
    logic [TW-1:0] tcnt;
    logic pend, flush_q, timeout, stop, go_hold, handshake;

    assign lane      = cnt[LW-1:0];
    assign timeout   = (TIMEOUT != 0) && (tcnt == TMAX);
    // once a flush or timeout is pending, no new reads are issued so the word can close
    assign stop      = (state == FILL) && (flush || flush_q || timeout);
    assign go_hold   = stop && !pend;
    assign handshake = (state == HOLD) && m_ready;
    assign m_valid   = (state == HOLD);
    assign fifo_ren  = !rst && (state != HOLD) && (|fifo_count) && !stop &&
                       ((cnt + CW'(pend)) < CW'(BYTES_PER_WORD));

    always_comb begin
        nxt = (state == IDLE) ? (fifo_ren ? FILL : IDLE) :
              (state == FILL) ? ((go_hold || (pend && cnt == LAST)) ? HOLD : FILL) :
              (m_ready ? IDLE : HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tcnt    <= '0;
            pend    <= 1'b0;
            flush_q <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
        end else begin
            state <= nxt;
            pend  <= fifo_ren;
            if (handshake) begin
                cnt     <= '0;
                tcnt    <= '0;
                flush_q <= 1'b0;
                m_data  <= '0;
                m_keep  <= '0;
            end else begin
                flush_q <= (state == FILL) && (flush || flush_q) && (nxt == FILL);
                if (pend) begin
                    m_data[8*lane +: 8] <= fifo_rdata;
                    m_keep[lane]        <= 1'b1;
                    cnt                 <= cnt + 1'b1;
                    tcnt                <= '0;
                end else if (state == FILL && tcnt != TMAX) begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: table-driven and directed checks of the packer against a behavioural upstream FIFO.
module tb_fifo_word_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        m_ready = 1'b1;
    logic        fifo_ren, m_valid;
    logic [4:0]  fifo_count;
    logic [7:0]  fifo_rdata = 8'h00;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic [7:0]  mem [64];
    int wr = 0, rd = 0, nreads = 0, since_read = 0, bad_reads = 0;
    int passed = 0, total = 0;

    typedef struct {
        int          n;
        logic [31:0] src;
        bit          fl;
        logic [31:0] ed;
        logic [3:0]  ek;
        int          lo;
        int          hi;
    } vec_t;
    vec_t vecs [6];

    fifo_word_packer #(.TIMEOUT(8), .MAX_DATA(16)) dut (
        .clk(clk), .rst(rst), .fifo_count(fifo_count), .fifo_ren(fifo_ren),
        .fifo_rdata(fifo_rdata), .flush(flush), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep)
    );

    always #5 clk = ~clk;
    assign fifo_count = 5'(wr - rd);

    // upstream FIFO: data appears the cycle after a read
    always @(posedge clk) begin
        since_read <= fifo_ren ? 0 : since_read + 1;
        if (fifo_ren) begin
            if (wr == rd) bad_reads <= bad_reads + 1;
            fifo_rdata <= mem[rd % 64];
            rd         <= rd + 1;
            nreads     <= nreads + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr % 64] = b;
        wr++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // steps until m_valid, pulsing flush one cycle after the last expected capture when fl is set
    task automatic await_word(input int target, input bit fl, output int idle, output bit got);
        bit fired = 0;
        got  = 0;
        idle = -1;
        for (int c = 0; c < 40; c++) begin
            if (fl && !fired && nreads == target && since_read >= 1) begin
                flush = 1'b1;
                fired = 1;
            end
            step();
            flush = 1'b0;
            if (m_valid) begin
                got  = 1;
                idle = since_read;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   idle, r0, hits;
        bit   got;
        logic [31:0] held;
        vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF, 1, 1};
        vecs[1] = '{4, 32'hDDCCBBAA, 1'b0, 32'hDDCCBBAA, 4'hF, 1, 1};
        vecs[2] = '{2, 32'h0000BBAA, 1'b0, 32'h0000BBAA, 4'h3, 9, 11};
        vecs[3] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'h1, 2, 2};
        vecs[4] = '{3, 32'h00030201, 1'b1, 32'h00030201, 4'h7, 2, 2};
        vecs[5] = '{3, 32'h00F0E0D0, 1'b0, 32'h00F0E0D0, 4'h7, 9, 11};

        // reset holds everything at zero even with data waiting upstream
        push(8'h77);
        step();
        step();
        chk("rst_ren", {31'd0, fifo_ren}, 32'd0);
        chk("rst_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_data", m_data, 32'd0);
        chk("rst_keep", {28'd0, m_keep}, 32'd0);
        rst = 1'b0;
        await_word(1, 1'b1, idle, got);
        chk("first_data", m_data, 32'h00000077);
        chk("first_keep", {28'd0, m_keep}, 32'h1);
        step();

        // flush in IDLE with nothing upstream does nothing
        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_flush_ren", {31'd0, fifo_ren}, 32'd0);
            chk("idle_flush_valid", {31'd0, m_valid}, 32'd0);
        end
        flush = 1'b0;
        step();

        for (int v = 0; v < 6; v++) begin
            r0 = nreads;
            for (int i = 0; i < vecs[v].n; i++) begin
                logic [31:0] s;
                s = vecs[v].src;
                push(s[8*i +: 8]);
            end
            await_word(r0 + vecs[v].n, vecs[v].fl, idle, got);
            chk($sformatf("v%0d_valid", v), {31'd0, got}, 32'd1);
            chk($sformatf("v%0d_data", v), m_data, vecs[v].ed);
            chk($sformatf("v%0d_keep", v), {28'd0, m_keep}, {28'd0, vecs[v].ek});
            chk_rng($sformatf("v%0d_latency", v), idle, vecs[v].lo, vecs[v].hi);
            chk($sformatf("v%0d_reads", v), 32'(nreads - r0), 32'(vecs[v].n));
            step();
            chk($sformatf("v%0d_post_valid", v), {31'd0, m_valid}, 32'd0);
            chk($sformatf("v%0d_post_keep", v), {28'd0, m_keep}, 32'd0);
            step();
        end

        // backpressure: word stays put, no fifth read while a byte waits upstream
        m_ready = 1'b0;
        r0 = nreads;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
        await_word(r0 + 4, 1'b0, idle, got);
        chk("stall_data", m_data, 32'h44332211);
        chk("stall_keep", {28'd0, m_keep}, 32'hF);
        held = m_data;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            hits += (m_valid && m_data == held && !fifo_ren) ? 1 : 0;
        end
        chk("stall_stable_cycles", 32'(hits), 32'd10);
        chk("stall_no_fifth_read", 32'(nreads - r0), 32'd4);
        m_ready = 1'b1;
        await_word(r0 + 5, 1'b1, idle, got);
        chk("tail_data", m_data, 32'h00000055);
        chk("tail_keep", {28'd0, m_keep}, 32'h1);
        step();
        step();

        // reset with three bytes held and the fourth read in flight
        r0 = nreads;
        push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        for (int c = 0; c < 20 && nreads != r0 + 4; c++) step();
        chk("mid_reads", 32'(nreads - r0), 32'd4);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_rst_data", m_data, 32'd0);
        chk("mid_rst_keep", {28'd0, m_keep}, 32'd0);
        chk("mid_rst_ren", {31'd0, fifo_ren}, 32'd0);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            hits += m_valid ? 1 : 0;
        end
        chk("mid_no_stray_word", 32'(hits), 32'd0);
        r0 = nreads;
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        await_word(r0 + 4, 1'b0, idle, got);
        chk("fresh_data", m_data, 32'hB4B3B2B1);
        chk("fresh_keep", {28'd0, m_keep}, 32'hF);
        step();

        chk("no_empty_reads", 32'(bad_reads), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
